// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op encoding and FSM state encoding.
// The op encoding is also used by the control unit's ALUControl decoder.
package alu_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_XOR     = 3'b001;
  localparam logic [2:0] OP_SLL     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_MUL     = 3'b100;
  localparam logic [2:0] OP_ADD     = 3'b101;
  localparam logic [2:0] OP_SRA     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // True when the op needs the iterative multiplier.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier core. Retires MUL_BITS_PER_STEP multiplier
// bits per cycle; returns the low WIDTH bits of the product, which are the
// same for signed and unsigned operands.
module alu_iter_mul #(
  parameter int WIDTH             = 32,
  parameter int MUL_BITS_PER_STEP = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int STEPS = WIDTH / MUL_BITS_PER_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_pp;

  // Partial product of the shifted multiplicand and the low multiplier bits.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_BITS_PER_STEP; j++) begin
      if (r_b[j]) begin
        w_pp = w_pp + (r_a << j);
      end else begin
        w_pp = w_pp;
      end
    end
  end

  // Operand load on start, then one step per cycle until the count runs out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_start) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_acc   <= '0;
      r_count <= CW'(STEPS);
    end else if (r_count != '0) begin
      r_acc   <= r_acc + w_pp;
      r_a     <= r_a << MUL_BITS_PER_STEP;
      r_b     <= r_b >> MUL_BITS_PER_STEP;
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // The last step's partial product is folded in combinationally so the
  // result is available on the same edge the count reaches zero.
  assign o_busy    = (r_count != '0);
  assign o_done    = (r_count == CW'(1));
  assign o_product = r_acc + w_pp;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// complete in one cycle; MUL runs on the iterative core.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int MUL_BITS_PER_STEP = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] read_data_1_in,
  input  logic [WIDTH-1:0] read_data_2_in,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic [WIDTH-1:0] ALU_result_out,
  output logic             zero_out,
  output logic             err_out
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_next;
  logic             w_ready;
  logic             w_accept;
  logic             w_accept_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_err;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic             r_valid;

  assign w_ready      = (r_state == ST_IDLE) | ((r_state == ST_DONE) & result_ready_in);
  assign w_accept     = valid_in & w_ready;
  assign w_accept_mul = w_accept & is_mul_op(op_in);
  assign w_shamt      = read_data_2_in[SHW-1:0];

  alu_iter_mul #(
    .WIDTH             (WIDTH),
    .MUL_BITS_PER_STEP (MUL_BITS_PER_STEP)
  ) u_mul (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_start   (w_accept_mul),
    .i_a       (read_data_1_in),
    .i_b       (read_data_2_in),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Single-cycle datapath; only sampled at accept, so it reads the ports directly.
  always_comb begin
    w_alu_result = '0;
    w_alu_err    = 1'b0;
    case (op_in)
      OP_AND:     w_alu_result = read_data_1_in & read_data_2_in;
      OP_XOR:     w_alu_result = read_data_1_in ^ read_data_2_in;
      OP_SLL:     w_alu_result = read_data_1_in << w_shamt;
      OP_SUB:     w_alu_result = read_data_1_in - read_data_2_in;
      OP_ADD:     w_alu_result = read_data_1_in + read_data_2_in;
      OP_SRA:     w_alu_result = $unsigned($signed(read_data_1_in) >>> w_shamt);
      OP_MUL:     w_alu_result = '0;
      OP_ILLEGAL: begin
        w_alu_result = '0;
        w_alu_err    = 1'b1;
      end
      default: begin
        w_alu_result = '0;
        w_alu_err    = 1'b1;
      end
    endcase
  end

  // Next-state logic for the IDLE/MUL/DONE controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = is_mul_op(op_in) ? ST_MUL : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_next = ST_DONE;
        end else if (!w_mul_busy) begin
          // Core lost its count without finishing: recover rather than hang.
          w_next = ST_IDLE;
        end else begin
          w_next = ST_MUL;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_next = is_mul_op(op_in) ? ST_MUL : ST_DONE;
        end else if (result_ready_in) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Output register: loads single-cycle results at accept, MUL results at
  // the final step, and drops valid when the consumer retires the result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_accept && !is_mul_op(op_in)) begin
      r_result <= w_alu_result;
      r_zero   <= (w_alu_result == '0);
      r_err    <= w_alu_err;
      r_valid  <= 1'b1;
    end else if (w_accept) begin
      r_valid  <= 1'b0;
    end else if ((r_state == ST_MUL) && w_mul_done) begin
      r_result <= w_mul_product;
      r_zero   <= (w_mul_product == '0);
      r_err    <= 1'b0;
      r_valid  <= 1'b1;
    end else if ((r_state == ST_DONE) && result_ready_in) begin
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= r_valid;
    end
  end

  assign ready_out        = w_ready;
  assign result_valid_out = r_valid;
  assign ALU_result_out   = r_result;
  assign zero_out         = r_zero;
  assign err_out          = r_err;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, random ops against a
// behavioural model, and hand-written handshake/reset sequences.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rvalid;
  logic        rready;
  logic [31:0] res;
  logic        zero;
  logic        err;

  logic        valid4;
  logic        ready4;
  logic [2:0]  op4;
  logic [31:0] a4;
  logic [31:0] b4;
  logic        rvalid4;
  logic        rready4;
  logic [31:0] res4;
  logic        zero4;
  logic        err4;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(32), .MUL_BITS_PER_STEP(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .ready_out(ready),
    .op_in(op), .read_data_1_in(a), .read_data_2_in(b),
    .result_valid_out(rvalid), .result_ready_in(rready),
    .ALU_result_out(res), .zero_out(zero), .err_out(err)
  );

  alu_multicycle #(.WIDTH(32), .MUL_BITS_PER_STEP(4)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid4), .ready_out(ready4),
    .op_in(op4), .read_data_1_in(a4), .read_data_2_in(b4),
    .result_valid_out(rvalid4), .result_ready_in(rready4),
    .ALU_result_out(res4), .zero_out(zero4), .err_out(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: what the ALU should return, written from the op definitions.
  function automatic logic [33:0] model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        e;
    int          sh;
    sh = int'(y % 32'd32);
    e  = 1'b0;
    case (mop)
      3'd0: r = x & y;
      3'd1: r = x ^ y;
      3'd2: r = x << sh;
      3'd3: r = x - y;
      3'd4: r = x * y;
      3'd5: r = x + y;
      3'd6: r = $unsigned($signed(x) >>> sh);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {r, (r == 32'd0), e};
  endfunction

  // Issue one op from IDLE, wait for the result, check it, then retire it.
  task automatic run_op(input string name, input logic [2:0] mop, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic ez,
                        input logic ee, input int elat);
    int lat;
    int rdy_high;
    chk({name, " ready_idle"}, 32'(ready), 32'd1);
    valid = 1'b1; op = mop; a = x; b = y; rready = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0; rdy_high = 0;
    while (!rvalid && lat < 200) begin
      if (ready) rdy_high++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " ready_low_busy"}, 32'(rdy_high), 32'd0);
    chk({name, " result"}, res, er);
    chk({name, " zero"}, 32'(zero), 32'(ez));
    chk({name, " err"}, 32'(err), 32'(ee));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({name, " retired"}, 32'(rvalid), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [33:0] m;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;

    vecs[0]  = '{3'b101, 32'd7,          32'hFFFFFFFD, 32'd4,          1'b0, 1'b0, 0};
    vecs[1]  = '{3'b100, 32'hFFFFFFFA,   32'd7,        32'hFFFFFFD6,   1'b0, 1'b0, 32};
    vecs[2]  = '{3'b110, 32'h80000000,   32'h00000024, 32'hF8000000,   1'b0, 1'b0, 0};
    vecs[3]  = '{3'b010, 32'd1,          32'd31,       32'h80000000,   1'b0, 1'b0, 0};
    vecs[4]  = '{3'b111, 32'h12345678,   32'h9ABCDEF0, 32'd0,          1'b1, 1'b1, 0};
    vecs[5]  = '{3'b000, 32'h0000000C,   32'h0000000A, 32'h00000008,   1'b0, 1'b0, 0};
    vecs[6]  = '{3'b011, 32'd5,          32'd5,        32'd0,          1'b1, 1'b0, 0};
    vecs[7]  = '{3'b101, 32'h7FFFFFFF,   32'd1,        32'h80000000,   1'b0, 1'b0, 0};
    vecs[8]  = '{3'b011, 32'd0,          32'd1,        32'hFFFFFFFF,   1'b0, 1'b0, 0};
    vecs[9]  = '{3'b001, 32'h000000F0,   32'h000000FF, 32'h0000000F,   1'b0, 1'b0, 0};
    vecs[10] = '{3'b100, 32'h00010000,   32'h00010000, 32'd0,          1'b1, 1'b0, 32};
    vecs[11] = '{3'b010, 32'h00000003,   32'hFFFFFFE1, 32'h00000006,   1'b0, 1'b0, 0};

    rst_n = 1'b0; valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rready = 1'b0;
    valid4 = 1'b0; op4 = 3'd0; a4 = 32'd0; b4 = 32'd0; rready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset result", res, 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ready", 32'(ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_err, vecs[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d", i), rop, ra, rb, m[33:2], m[1], m[0], (rop == 3'd4) ? 32 : 0);
    end

    // Hold the result for five cycles, then retire and accept back-to-back.
    valid = 1'b1; op = 3'b011; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; a = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d valid", i), 32'(rvalid), 32'd1);
      chk($sformatf("hold%0d result", i), res, 32'd0);
      chk($sformatf("hold%0d zero", i), 32'(zero), 32'd1);
      chk($sformatf("hold%0d ready", i), 32'(ready), 32'd0);
      @(posedge clk); #1;
    end
    valid = 1'b1; op = 3'b001; a = 32'h000000F0; b = 32'h000000FF; rready = 1'b1;
    #1 chk("b2b ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; rready = 1'b0;
    chk("b2b valid", 32'(rvalid), 32'd1);
    chk("b2b result", res, 32'h0000000F);
    chk("b2b zero", 32'(zero), 32'd0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("b2b retired", 32'(rvalid), 32'd0);

    // Step-4 multiplier: eight MUL cycles.
    valid4 = 1'b1; op4 = 3'b100; a4 = 32'hFFFFFFFA; b4 = 32'd7;
    @(posedge clk); #1;
    valid4 = 1'b0;
    lat = 0;
    while (!rvalid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("step4 latency", 32'(lat), 32'd8);
    chk("step4 result", res4, 32'hFFFFFFD6);
    chk("step4 err", 32'(err4), 32'd0);
    rready4 = 1'b1;
    @(posedge clk); #1;
    rready4 = 1'b0;

    // Reset during MUL cycle 10 aborts the operation.
    valid = 1'b1; op = 3'b100; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort rvalid", 32'(rvalid), 32'd0);
    chk("abort result", res, 32'd0);
    chk("abort zero", 32'(zero), 32'd0);
    chk("abort err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rvalid) lat++;
    end
    chk("abort no result", 32'(lat), 32'd0);
    chk("abort ready", 32'(ready), 32'd1);

    // After the abort the unit must still work normally.
    run_op("post_abort", 3'b000, 32'h0000000C, 32'h0000000A, 32'h00000008, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
